// File: rtl/gemm_tile_scheduler_pkg.sv
// gemm_tile_scheduler_pkg: shared sizes, types and FSM states for the GEMM tile scheduler
package gemm_tile_scheduler_pkg;
    localparam int N = 4;
    localparam int LOG_N = 2;
    localparam int TILE_W = 4;
    localparam int ADDR_W = 16;
    localparam int TILE_WORDS = N * N;
    localparam int LOG_T = 2 * LOG_N;
    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [TILE_W-1:0] cnt_t;
    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_WRITE, S_DONE} sched_state_t;
endpackage

// File: rtl/gemm_tile_scheduler_if.sv
// gemm_tile_scheduler_if: job descriptor, array-pass and C-writeback signals
// slave: scheduler side (accepts jobs, drives the array and writeback requests)
// master: host/array side (offers jobs, reports pass done, accepts writebacks)
interface gemm_tile_scheduler_if;
    import gemm_tile_scheduler_pkg::*;
    logic  job_valid_i;
    logic  job_ready_o;
    cnt_t  job_m_tiles_i;
    cnt_t  job_k_tiles_i;
    cnt_t  job_n_tiles_i;
    addr_t job_a_base_i;
    addr_t job_b_base_i;
    addr_t job_c_base_i;
    logic  arr_start_o;
    logic  arr_done_i;
    addr_t a_addr_o;
    addr_t b_addr_o;
    logic  acc_clear_o;
    logic  c_write_o;
    logic  c_ready_i;
    addr_t c_addr_o;
    logic  busy_o;
    logic  job_done_o;
    logic  job_err_o;
    modport slave (
        input  job_valid_i, job_m_tiles_i, job_k_tiles_i, job_n_tiles_i,
               job_a_base_i, job_b_base_i, job_c_base_i, arr_done_i, c_ready_i,
        output job_ready_o, arr_start_o, a_addr_o, b_addr_o, acc_clear_o,
               c_write_o, c_addr_o, busy_o, job_done_o, job_err_o
    );
    modport master (
        output job_valid_i, job_m_tiles_i, job_k_tiles_i, job_n_tiles_i,
               job_a_base_i, job_b_base_i, job_c_base_i, arr_done_i, c_ready_i,
        input  job_ready_o, arr_start_o, a_addr_o, b_addr_o, acc_clear_o,
               c_write_o, c_addr_o, busy_o, job_done_o, job_err_o
    );
endinterface

// File: rtl/gemm_tile_scheduler_tile_addr_gen.sv
// gemm_tile_scheduler_tile_addr_gen: m/n/k counters and running A/B/C tile pointers
// in:  load (latch descriptor, zero counters), step_k (next k), step_n (next output tile)
// out: a/b/c tile addresses, acc_clear, last_k and last_tile flags
module gemm_tile_scheduler_tile_addr_gen
    import gemm_tile_scheduler_pkg::*;
(
    input  logic  clk_i,
    input  logic  rst_i,
    input  logic  load,
    input  logic  step_k,
    input  logic  step_n,
    input  cnt_t  mt,
    input  cnt_t  kt,
    input  cnt_t  nt,
    input  addr_t a_base,
    input  addr_t b_base,
    input  addr_t c_base,
    output addr_t a_addr,
    output addr_t b_addr,
    output addr_t c_addr,
    output logic  acc_clear,
    output logic  last_k,
    output logic  last_tile
);
    localparam addr_t T = addr_t'(TILE_WORDS);
    cnt_t  mt_q, kt_q, nt_q, m, n, k;
    addr_t a_row, b_col, b_base_q;
    logic  n_wrap;
    // a_row tracks a_base + m*Kt*T, b_col tracks b_base + n*T
    addr_t b_stride;
    assign b_stride  = addr_t'(nt_q) << LOG_T;
    assign n_wrap    = n == cnt_t'(nt_q - 1'b1);
    assign last_k    = k == cnt_t'(kt_q - 1'b1);
    assign last_tile = n_wrap && (m == cnt_t'(mt_q - 1'b1));
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            {mt_q, kt_q, nt_q, m, n, k} <= '0;
            {a_row, b_col, b_base_q, a_addr, b_addr, c_addr} <= '0;
            acc_clear <= 1'b0;
        end else if (load) begin
            {mt_q, kt_q, nt_q} <= {mt, kt, nt};
            {m, n, k} <= '0;
            b_base_q <= b_base;
            {a_row, a_addr} <= {a_base, a_base};
            {b_col, b_addr} <= {b_base, b_base};
            c_addr <= c_base;
            acc_clear <= 1'b1;
        end else if (step_k) begin
            k <= k + 1'b1;
            a_addr <= a_addr + T;
            b_addr <= b_addr + b_stride;
            acc_clear <= 1'b0;
        end else if (step_n) begin
            k <= '0;
            acc_clear <= 1'b1;
            c_addr <= c_addr + T;
            if (n_wrap) begin
                n <= '0;
                m <= m + 1'b1;
                // a_addr sits on the row's last k tile, so the next row starts one tile on
                a_row <= a_addr + T;
                a_addr <= a_addr + T;
                b_col <= b_base_q;
                b_addr <= b_base_q;
            end else begin
                n <= n + 1'b1;
                a_addr <= a_row;
                b_col <= b_col + T;
                b_addr <= b_col + T;
            end
        end
    end
endmodule

// File: rtl/gemm_tile_scheduler.sv
// gemm_tile_scheduler: walks output tiles (m,n) with k innermost, issuing array passes and C writebacks
// ports: clk_i, rst_i (async, active-high), bus (slave modport of gemm_tile_scheduler_if)
module gemm_tile_scheduler
    import gemm_tile_scheduler_pkg::*;
(
    input logic clk_i,
    input logic rst_i,
    gemm_tile_scheduler_if.slave bus
);
    sched_state_t state;
    logic err, load, step_k, step_n, last_k, last_tile, any_zero;
    assign any_zero = (bus.job_m_tiles_i == '0) || (bus.job_k_tiles_i == '0) || (bus.job_n_tiles_i == '0);
    assign load   = (state == S_IDLE) && bus.job_valid_i && bus.job_ready_o;
    assign step_k = (state == S_WAIT) && bus.arr_done_i && !last_k;
    assign step_n = (state == S_WRITE) && bus.c_ready_i && !last_tile;
    // ready is gated by rst_i so it reads 0 throughout reset even though S_IDLE is the reset state
    assign bus.job_ready_o = (state == S_IDLE) && !rst_i;
    assign bus.arr_start_o = state == S_ISSUE;
    assign bus.c_write_o   = state == S_WRITE;
    assign bus.busy_o      = state != S_IDLE;
    assign bus.job_done_o  = state == S_DONE;
    assign bus.job_err_o   = (state == S_DONE) && err;
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= S_IDLE;
            err <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (load) begin
                    err <= any_zero;
                    state <= any_zero ? S_DONE : S_ISSUE;
                end
                S_ISSUE: state <= S_WAIT;
                S_WAIT:  if (bus.arr_done_i) state <= last_k ? S_WRITE : S_ISSUE;
                S_WRITE: if (bus.c_ready_i) state <= last_tile ? S_DONE : S_ISSUE;
                S_DONE: begin
                    err <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
    gemm_tile_scheduler_tile_addr_gen u_addr (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .load      (load),
        .step_k    (step_k),
        .step_n    (step_n),
        .mt        (bus.job_m_tiles_i),
        .kt        (bus.job_k_tiles_i),
        .nt        (bus.job_n_tiles_i),
        .a_base    (bus.job_a_base_i),
        .b_base    (bus.job_b_base_i),
        .c_base    (bus.job_c_base_i),
        .a_addr    (bus.a_addr_o),
        .b_addr    (bus.b_addr_o),
        .c_addr    (bus.c_addr_o),
        .acc_clear (bus.acc_clear_o),
        .last_k    (last_k),
        .last_tile (last_tile)
    );
endmodule

// File: tb/tb_gemm_tile_scheduler.sv
// tb_gemm_tile_scheduler: event-queue model of the tile walk, per-cycle compare, directed jobs
module tb_gemm_tile_scheduler;
    typedef struct {
        bit          w;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] c;
        bit          clr;
    } ev_t;

    logic clk_i, rst_i;
    gemm_tile_scheduler_if bus();
    gemm_tile_scheduler dut (.clk_i(clk_i), .rst_i(rst_i), .bus(bus));

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int n_cmp = 0, n_err = 0, exp_jobs = 0;
    bit exp_err, last_err;
    ev_t q[$];
    logic [15:0] obs_a[$], obs_b[$], obs_c[$];
    bit obs_clr[$];
    logic [15:0] last_a, last_b;

    localparam logic [15:0] AB = 16'h100, BB = 16'h200, CB = 16'h300;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic rst_chk(input string nm);
        chk({nm, "_ready"}, bus.job_ready_o, 0);
        chk({nm, "_outs"}, {bus.arr_start_o, bus.acc_clear_o, bus.c_write_o,
                           bus.busy_o, bus.job_done_o, bus.job_err_o}, 0);
        chk({nm, "_addr"}, {bus.a_addr_o | bus.b_addr_o | bus.c_addr_o}, 0);
    endtask

    // expected passes and writebacks straight from the address formulas
    task automatic build(input int mt, input int kt, input int nt);
        ev_t e;
        exp_err = (mt == 0) || (kt == 0) || (nt == 0);
        exp_jobs++;
        if (exp_err) return;
        for (int m = 0; m < mt; m++)
            for (int n = 0; n < nt; n++) begin
                for (int k = 0; k < kt; k++) begin
                    e.w = 0;
                    e.a = AB + 16'((m * kt + k) * 16);
                    e.b = BB + 16'((k * nt + n) * 16);
                    e.c = 0;
                    e.clr = (k == 0);
                    q.push_back(e);
                end
                e.w = 1;
                e.a = 0;
                e.b = 0;
                e.clr = 0;
                e.c = CB + 16'((m * nt + n) * 16);
                q.push_back(e);
            end
    endtask

    always @(negedge clk_i) begin
        if (!rst_i) begin
            if (bus.arr_start_o) begin
                obs_a.push_back(bus.a_addr_o);
                obs_b.push_back(bus.b_addr_o);
                obs_clr.push_back(bus.acc_clear_o);
                last_a = bus.a_addr_o;
                last_b = bus.b_addr_o;
                chk("start_expected", (q.size() > 0 && !q[0].w), 1);
                if (q.size() > 0 && !q[0].w) begin
                    chk("start_a", bus.a_addr_o, q[0].a);
                    chk("start_b", bus.b_addr_o, q[0].b);
                    chk("start_clr", bus.acc_clear_o, q[0].clr);
                    void'(q.pop_front());
                end
            end
            if (bus.c_write_o) begin
                chk("write_expected", (q.size() > 0 && q[0].w), 1);
                chk("start_write_excl", bus.arr_start_o, 0);
                if (q.size() > 0 && q[0].w) begin
                    chk("write_c", bus.c_addr_o, q[0].c);
                    if (bus.c_ready_i) begin
                        obs_c.push_back(bus.c_addr_o);
                        void'(q.pop_front());
                    end
                end
            end
            if (bus.arr_done_i && bus.busy_o && !bus.arr_start_o && !bus.c_write_o && !bus.job_done_o) begin
                chk("hold_a", bus.a_addr_o, last_a);
                chk("hold_b", bus.b_addr_o, last_b);
            end
            if (bus.job_done_o) begin
                last_err = bus.job_err_o;
                chk("done_expected", exp_jobs > 0, 1);
                chk("done_q_empty", q.size(), 0);
                chk("done_err", bus.job_err_o, exp_err);
                exp_jobs--;
            end
        end
    end

    task automatic clear_obs();
        obs_a.delete();
        obs_b.delete();
        obs_c.delete();
        obs_clr.delete();
    endtask

    // dly: cycles from start to arr_done; bp: stall cycles on each writeback;
    // rst_at: reset while waiting on that start number (0 = never); done_cyc: cycles from acceptance
    task automatic run_job(input int mt, input int kt, input int nt, input int dly,
                           input int bp, input int rst_at, output int done_cyc);
        int wcnt = 0, rc = 0, starts = 0;
        clear_obs();
        build(mt, kt, nt);
        @(posedge clk_i); #1;
        chk("ready_pre", bus.job_ready_o, 1);
        bus.job_valid_i = 1;
        bus.job_m_tiles_i = 4'(mt);
        bus.job_k_tiles_i = 4'(kt);
        bus.job_n_tiles_i = 4'(nt);
        bus.job_a_base_i = AB;
        bus.job_b_base_i = BB;
        bus.job_c_base_i = CB;
        @(posedge clk_i); #1;
        bus.job_valid_i = 0;
        bus.job_m_tiles_i = 4'hf;
        bus.job_k_tiles_i = 4'h0;
        bus.job_n_tiles_i = 4'h7;
        bus.job_a_base_i = 16'hdead;
        bus.job_b_base_i = 16'hbeef;
        bus.job_c_base_i = 16'h5a5a;
        done_cyc = -1;
        for (int i = 1; i <= 3000 && done_cyc < 0; i++) begin
            if (i > 1) begin
                @(posedge clk_i); #1;
            end
            bus.arr_done_i = 0;
            bus.c_ready_i = 0;
            if (bus.job_done_o) done_cyc = i;
            if (bus.arr_start_o) begin
                starts++;
                wcnt = dly;
            end else if (wcnt > 0) begin
                wcnt--;
                if (wcnt == 0) bus.arr_done_i = 1;
            end
            if (bus.c_write_o) begin
                if (rc < bp) begin
                    rc++;
                    bus.arr_done_i = rc[0];
                end else begin
                    rc = 0;
                    bus.c_ready_i = 1;
                end
            end
            if (rst_at > 0 && starts == rst_at && !bus.arr_start_o && wcnt > 0) begin
                #2 rst_i = 1;
                #1 rst_chk("mid_rst");
                @(posedge clk_i); #1;
                rst_chk("mid_rst_hold");
                rst_i = 0;
                #1 chk("ready_after_rst", bus.job_ready_o, 1);
                q.delete();
                exp_jobs = 0;
                done_cyc = 0;
                break;
            end
        end
        bus.arr_done_i = 0;
        bus.c_ready_i = 0;
        chk("job_timeout", done_cyc >= 0, 1);
        if (rst_at == 0 && done_cyc > 0) begin
            @(posedge clk_i); #1;
            chk("ready_after", bus.job_ready_o, 1);
            chk("busy_after", bus.busy_o, 0);
        end
    endtask

    task automatic check_t1(input string nm);
        chk({nm, "_nstart"}, obs_a.size(), 1);
        chk({nm, "_a"}, obs_a[0], 16'h100);
        chk({nm, "_b"}, obs_b[0], 16'h200);
        chk({nm, "_clr"}, obs_clr[0], 1);
        chk({nm, "_c"}, obs_c[0], 16'h300);
        chk({nm, "_err"}, last_err, 0);
    endtask

    initial begin
        int dc;
        logic [15:0] ea[4], eb[4], ec[4];
        rst_i = 1;
        bus.job_valid_i = 0;
        bus.job_m_tiles_i = 0;
        bus.job_k_tiles_i = 0;
        bus.job_n_tiles_i = 0;
        bus.job_a_base_i = 0;
        bus.job_b_base_i = 0;
        bus.job_c_base_i = 0;
        bus.arr_done_i = 0;
        bus.c_ready_i = 0;
        repeat (2) @(negedge clk_i);
        rst_chk("reset");
        @(posedge clk_i); #1;
        rst_i = 0;
        #1 chk("ready_release", bus.job_ready_o, 1);
        // spurious arr_done in S_IDLE
        bus.arr_done_i = 1;
        repeat (3) @(posedge clk_i);
        #1 bus.arr_done_i = 0;
        chk("idle_spur_busy", bus.busy_o, 0);
        chk("idle_spur_ready", bus.job_ready_o, 1);

        run_job(1, 1, 1, 1, 0, 0, dc);
        check_t1("t1");
        chk("t1_start_lat", dc > 3, 1);

        run_job(1, 3, 1, 2, 0, 0, dc);
        ea = '{16'h100, 16'h110, 16'h120, 16'h0};
        eb = '{16'h200, 16'h210, 16'h220, 16'h0};
        chk("t2_nstart", obs_a.size(), 3);
        chk("t2_nwrite", obs_c.size(), 1);
        chk("t2_c", obs_c[0], 16'h300);
        for (int i = 0; i < 3; i++) begin
            chk("t2_a", obs_a[i], ea[i]);
            chk("t2_b", obs_b[i], eb[i]);
            chk("t2_clr", obs_clr[i], i == 0);
        end

        run_job(2, 1, 2, 1, 1, 0, dc);
        ea = '{16'h100, 16'h100, 16'h110, 16'h110};
        eb = '{16'h200, 16'h210, 16'h200, 16'h210};
        ec = '{16'h300, 16'h310, 16'h320, 16'h330};
        chk("t3_nstart", obs_a.size(), 4);
        for (int i = 0; i < 4; i++) begin
            chk("t3_a", obs_a[i], ea[i]);
            chk("t3_b", obs_b[i], eb[i]);
            chk("t3_c", obs_c[i], ec[i]);
        end

        run_job(1, 2, 2, 1, 5, 0, dc);
        chk("t4_nwrite", obs_c.size(), 2);
        chk("t4_c1", obs_c[1], 16'h310);

        run_job(2, 0, 2, 1, 0, 0, dc);
        chk("t5_done_lat", dc, 1);
        chk("t5_nstart", obs_a.size(), 0);
        chk("t5_err", last_err, 1);

        run_job(1, 3, 1, 3, 0, 2, dc);
        chk("t6_nstart_before_rst", obs_a.size(), 2);
        run_job(1, 1, 1, 1, 0, 0, dc);
        check_t1("t6");

        run_job(2, 3, 3, 2, 1, 0, dc);
        chk("t7_nstart", obs_a.size(), 18);
        chk("t7_last_a", obs_a[17], 16'h150);
        chk("t7_last_b", obs_b[17], 16'h280);
        chk("t7_last_c", obs_c[5], 16'h350);

        repeat (2) @(posedge clk_i);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
